// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch
// stage (IF) and the load/store path of the memory stage (LS). Only one
// transaction is in flight at a time. LS normally wins, but IF is
// guaranteed a slot once LS has been granted STARVE_MAX times in a row
// while IF was waiting. Read data is steered back to whichever stage
// issued the read.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   if_req / if_addr        : fetch read request (held until granted)
//   if_gnt                  : fetch request accepted this cycle
//   if_rvalid / if_rdata    : fetch read response
//   ls_req / ls_we / ls_be  : load/store request, store flag, byte enables
//   ls_addr / ls_wdata      : load/store address and store data
//   ls_gnt                  : load/store request accepted this cycle
//   ls_rvalid / ls_rdata    : load response
//   mem_req .. mem_wdata    : request channel towards the memory
//   mem_gnt                 : memory accepts the current request
//   mem_rvalid / mem_rdata  : read response from the memory
//   busy                    : a read is outstanding
//   resp_err                : sticky, a response arrived with no read outstanding

module mem_port_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 32,
   parameter int DW         = 32
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DW-1:0]     if_rdata,

   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [DW/8-1:0]   ls_be,
   input  logic [AW-1:0]     ls_addr,
   input  logic [DW-1:0]     ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DW-1:0]     ls_rdata,

   output logic              mem_req,
   output logic              mem_we,
   output logic [DW/8-1:0]   mem_be,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DW-1:0]     mem_rdata,

   output logic              busy,
   output logic              resp_err
);

   localparam int BW = DW / 8;
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IF = 2'd1,
      WAIT_LS = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            resp_err_q, resp_err_d;

   logic            sel_if;
   logic            sel_ls;

   // Requester selection. Only an idle port may start a new transaction.
   // LS wins a tie unless IF has already been passed over STARVE_MAX
   // times, in which case IF takes this slot.
   always_comb begin
      sel_if = 1'b0;
      sel_ls = 1'b0;
      if (state_q == IDLE) begin
         if (if_req && (!ls_req || (starve_cnt_q == STARVE_LIM))) begin
            sel_if = 1'b1;
         end else if (ls_req) begin
            sel_ls = 1'b1;
         end
      end
   end

   // Memory request channel. A fetch is always a full-word read, so the
   // write-side fields are fixed for IF. With nothing selected every field
   // is held at zero so the bus stays quiet.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (sel_if) begin
         mem_req   = 1'b1;
         mem_we    = 1'b0;
         mem_be    = {BW{1'b1}};
         mem_addr  = if_addr;
         mem_wdata = '0;
      end else if (sel_ls) begin
         mem_req   = 1'b1;
         mem_we    = ls_we;
         mem_be    = ls_be;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end
   end

   // Grants and response steering. The grant is the memory's accept
   // qualified by the selection; the response goes only to the stage that
   // owns the outstanding read, and read data is zeroed when not valid.
   always_comb begin
      if_gnt    = sel_if & mem_gnt;
      ls_gnt    = sel_ls & mem_gnt;
      if_rvalid = (state_q == WAIT_IF) & mem_rvalid;
      ls_rvalid = (state_q == WAIT_LS) & mem_rvalid;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      ls_rdata  = ls_rvalid ? mem_rdata : '0;
   end

   // Next-state logic. A store is fire-and-forget, so only reads leave
   // IDLE; a response always returns the port to IDLE, which gives the
   // one-cycle bubble between a read response and the next request.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (if_gnt) begin
               state_d = WAIT_IF;
            end else if (ls_gnt && !ls_we) begin
               state_d = WAIT_LS;
            end
         end
         WAIT_IF, WAIT_LS: begin
            if (mem_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter: counts LS acceptances that happened while IF was
   // waiting. Any cycle without a fetch request, or an IF acceptance,
   // starts the count over. It saturates so it can never wrap back below
   // the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || if_gnt) begin
         starve_cnt_d = '0;
      end else if (ls_gnt && (starve_cnt_q != STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + CW'(1);
      end
   end

   // A response with no read outstanding means the memory and this block
   // disagree (for example after a reset mid-read). It is dropped and
   // remembered until the next reset.
   always_comb begin
      resp_err_d = resp_err_q | ((state_q == IDLE) & mem_rvalid);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign resp_err = resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.

module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic            clock = 1'b0;
   logic            reset;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [DW-1:0]   if_rdata;
   logic            ls_req;
   logic            ls_we;
   logic [BW-1:0]   ls_be;
   logic [AW-1:0]   ls_addr;
   logic [DW-1:0]   ls_wdata;
   logic            ls_gnt;
   logic            ls_rvalid;
   logic [DW-1:0]   ls_rdata;
   logic            mem_req;
   logic            mem_we;
   logic [BW-1:0]   mem_be;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [DW-1:0]   mem_rdata;
   logic            busy;
   logic            resp_err;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .AW         (AW),
      .DW         (DW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .ls_req     (ls_req),
      .ls_we      (ls_we),
      .ls_be      (ls_be),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_gnt     (ls_gnt),
      .ls_rvalid  (ls_rvalid),
      .ls_rdata   (ls_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .resp_err   (resp_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the outstanding read (0 none, 1 IF, 2 LS),
   // how many LS grants IF has sat through, the sticky error, and the
   // remaining latency the emulated memory waits before responding.
   int m_owner = 0;
   int m_starve = 0;
   bit m_err = 1'b0;
   int m_wait = 0;

   // DUT outputs sampled at the falling edge of the most recent cycle.
   logic            s_if_gnt, s_ls_gnt, s_if_rvalid, s_ls_rvalid;
   logic            s_busy, s_resp_err, s_mem_req, s_mem_we;
   logic [BW-1:0]   s_mem_be;
   logic [AW-1:0]   s_mem_addr;
   logic [DW-1:0]   s_mem_wdata, s_if_rdata, s_ls_rdata;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr,
                                input logic lreq, input logic lwe,
                                input logic [BW-1:0] lbe, input logic [AW-1:0] laddr,
                                input logic [DW-1:0] lwdata, input logic gnt,
                                input logic rv, input logic [DW-1:0] rdata,
                                input logic rst);
      if_req     = ireq;
      if_addr    = iaddr;
      ls_req     = lreq;
      ls_we      = lwe;
      ls_be      = lbe;
      ls_addr    = laddr;
      ls_wdata   = lwdata;
      mem_gnt    = gnt;
      mem_rvalid = rv;
      mem_rdata  = rdata;
      reset      = rst;
   endtask

   // One clock cycle: compare every output against the model at the
   // falling edge, then advance the model at the rising edge.
   task automatic stepCycle();
      int pick;
      @(negedge clock);
      s_if_gnt    = if_gnt;
      s_ls_gnt    = ls_gnt;
      s_if_rvalid = if_rvalid;
      s_ls_rvalid = ls_rvalid;
      s_if_rdata  = if_rdata;
      s_ls_rdata  = ls_rdata;
      s_busy      = busy;
      s_resp_err  = resp_err;
      s_mem_req   = mem_req;
      s_mem_we    = mem_we;
      s_mem_be    = mem_be;
      s_mem_addr  = mem_addr;
      s_mem_wdata = mem_wdata;

      pick = 0;
      if (m_owner == 0) begin
         if (if_req && ls_req) pick = (m_starve >= STARVE_MAX) ? 1 : 2;
         else if (if_req) pick = 1;
         else if (ls_req) pick = 2;
      end

      checkOutput("mem_req", s_mem_req, pick != 0);
      checkOutput("if_gnt", s_if_gnt, (pick == 1) && mem_gnt);
      checkOutput("ls_gnt", s_ls_gnt, (pick == 2) && mem_gnt);
      if (pick == 1) begin
         checkOutput("mem_we_if", s_mem_we, 1'b0);
         checkOutput("mem_be_if", s_mem_be, {BW{1'b1}});
         checkOutput("mem_addr_if", s_mem_addr, if_addr);
         checkOutput("mem_wdata_if", s_mem_wdata, '0);
      end else if (pick == 2) begin
         checkOutput("mem_we_ls", s_mem_we, ls_we);
         checkOutput("mem_be_ls", s_mem_be, ls_be);
         checkOutput("mem_addr_ls", s_mem_addr, ls_addr);
         checkOutput("mem_wdata_ls", s_mem_wdata, ls_wdata);
      end else if (m_owner == 0) begin
         checkOutput("mem_quiet", {s_mem_we, s_mem_be, s_mem_addr, s_mem_wdata}, '0);
      end
      checkOutput("if_rvalid", s_if_rvalid, (m_owner == 1) && mem_rvalid);
      checkOutput("ls_rvalid", s_ls_rvalid, (m_owner == 2) && mem_rvalid);
      if ((m_owner == 1) && mem_rvalid) checkOutput("if_rdata", s_if_rdata, mem_rdata);
      if ((m_owner == 2) && mem_rvalid) checkOutput("ls_rdata", s_ls_rdata, mem_rdata);
      checkOutput("busy", s_busy, m_owner != 0);
      checkOutput("resp_err", s_resp_err, m_err);

      @(posedge clock);
      if (reset) begin
         m_owner  = 0;
         m_starve = 0;
         m_err    = 1'b0;
      end else begin
         if (!if_req) m_starve = 0;
         else if ((pick == 1) && mem_gnt) m_starve = 0;
         else if ((pick == 2) && mem_gnt) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
         if ((m_owner == 0) && mem_rvalid) m_err = 1'b1;
         if ((m_owner != 0) && mem_rvalid) m_owner = 0;
         else if ((pick == 1) && mem_gnt) m_owner = 1;
         else if ((pick == 2) && mem_gnt && !ls_we) m_owner = 2;
      end
      #1;
   endtask

   initial begin
      int exp_seq[7];
      int got_seq[$];
      int stores;
      bit if_done;
      int budget;
      int prev_owner;
      logic rv;
      logic [DW-1:0] rd;

      exp_seq = '{2, 2, 2, 2, 1, 2, 2};

      // Reset state.
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 1);
      @(posedge clock);
      #1;
      stepCycle();
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 0);
      stepCycle();
      checkOutput("reset_busy", s_busy, 1'b0);
      checkOutput("reset_mem_req", s_mem_req, 1'b0);

      // Single fetch with two-cycle memory latency.
      applyStimulus(1, 32'h100, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("fetch_gnt", s_if_gnt, 1'b1);
      checkOutput("fetch_addr", s_mem_addr, 32'h100);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("fetch_busy1", s_busy, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 1, 32'h00500093, 0);
      stepCycle();
      checkOutput("fetch_rvalid", s_if_rvalid, 1'b1);
      checkOutput("fetch_rdata", s_if_rdata, 32'h00500093);
      checkOutput("fetch_busy2", s_busy, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("fetch_idle", s_busy, 1'b0);

      // Simultaneous requests: LS load first, IF right after the response.
      applyStimulus(1, 32'h104, 1, 0, 4'hF, 32'h2000, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("tie_ls_gnt", s_ls_gnt, 1'b1);
      checkOutput("tie_if_gnt", s_if_gnt, 1'b0);
      applyStimulus(1, 32'h104, 0, 0, '0, '0, '0, 1, 1, 32'h0000ABCD, 0);
      stepCycle();
      checkOutput("tie_ls_rdata", s_ls_rdata, 32'h0000ABCD);
      applyStimulus(1, 32'h104, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("tie_if_after", s_if_gnt, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 1, 32'h13, 0);
      stepCycle();

      // Starvation guard: IF waits behind six back-to-back stores.
      stores  = 0;
      if_done = 1'b0;
      budget  = 0;
      while (!(if_done && stores == 6) && budget < 40) begin
         applyStimulus(!if_done, 32'h200, stores < 6, 1, 4'hF, 32'h4000 + 32'(stores * 4),
                       32'h1000 + 32'(stores), 1, m_owner != 0, 32'hCAFE0000, 0);
         stepCycle();
         if (s_if_gnt) begin
            got_seq.push_back(1);
            if_done = 1'b1;
         end
         if (s_ls_gnt) begin
            got_seq.push_back(2);
            stores++;
         end
         budget++;
      end
      checkOutput("starve_budget", budget < 40, 1'b1);
      checkOutput("starve_len", got_seq.size(), 7);
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("starve_slot%0d", i), (i < got_seq.size()) ? got_seq[i] : -1, exp_seq[i]);
      end

      // Partial-word store stays in IDLE with no response.
      applyStimulus(0, '0, 1, 1, 4'b0011, 32'h5000, 32'hDEADBEEF, 1, 0, '0, 0);
      stepCycle();
      checkOutput("store_we", s_mem_we, 1'b1);
      checkOutput("store_be", s_mem_be, 4'b0011);
      checkOutput("store_gnt", s_ls_gnt, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("store_idle", s_busy, 1'b0);
      checkOutput("store_no_rvalid", s_ls_rvalid, 1'b0);

      // Memory stalls the grant for three cycles.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 32'h340, 0, 0, '0, '0, '0, 0, 0, '0, 0);
         stepCycle();
         checkOutput("stall_req", s_mem_req, 1'b1);
         checkOutput("stall_addr", s_mem_addr, 32'h340);
         checkOutput("stall_gnt", s_if_gnt, 1'b0);
      end
      applyStimulus(1, 32'h340, 0, 0, '0, '0, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("stall_gnt4", s_if_gnt, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 1, 1, 32'h77, 0);
      stepCycle();

      // Reset while a load is outstanding, then a stray response.
      applyStimulus(0, '0, 1, 0, 4'hF, 32'h3000, '0, 1, 0, '0, 0);
      stepCycle();
      checkOutput("rst_ld_gnt", s_ls_gnt, 1'b1);
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 1);
      stepCycle();
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 1, 32'h12345678, 0);
      stepCycle();
      checkOutput("stray_ls_rvalid", s_ls_rvalid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 0);
         stepCycle();
         checkOutput("stray_resp_err", s_resp_err, 1'b1);
      end
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 1);
      stepCycle();
      applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 0);
      stepCycle();
      checkOutput("err_cleared", s_resp_err, 1'b0);

      // Randomized traffic with a well-behaved memory of 1-3 cycle latency.
      for (int n = 0; n < 400; n++) begin
         rv = 1'b0;
         if (m_owner != 0) begin
            if (m_wait == 0) rv = 1'b1;
            else m_wait--;
         end
         rd = $urandom;
         applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                       BW'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0, rv, rd, 0);
         prev_owner = m_owner;
         stepCycle();
         if (prev_owner == 0 && m_owner != 0) m_wait = $urandom_range(0, 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
